pc_unit: RTL



---
 rtl/pc_pkg.sv | 27 ++
 rtl/pc_unit_branch_cond_eval.sv | 38 +++
 rtl/pc_unit.sv | 117 +++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the program-counter unit.
//   cond_t     - 3-bit branch condition codes
//   pc_state_t - PC unit control FSM states
//   FLAG_*     - bit positions of Z, V, N inside the {N,V,Z} flags vector
package pc_pkg;

  typedef enum logic [2:0] {
    COND_NE  = 3'b000,
    COND_EQ  = 3'b001,
    COND_GT  = 3'b010,
    COND_LT  = 3'b011,
    COND_GE  = 3'b100,
    COND_LE  = 3'b101,
    COND_OVF = 3'b110,
    COND_AL  = 3'b111
  } cond_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } pc_state_t;

  localparam int FLAG_Z = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 2;

endpackage

// File: rtl/pc_unit_branch_cond_eval.sv
// branch_cond_eval: purely combinational branch condition evaluator.
// Ports:
//   cond     in  [2:0]  condition code (cond_t encoding)
//   flags    in  [2:0]  {N, V, Z}
//   cond_met out        1 when the condition holds for the given flags
module branch_cond_eval
  import pc_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] flags,
  output logic       cond_met
);

  logic flag_n;
  logic flag_v;
  logic flag_z;

  assign flag_n = flags[FLAG_N];
  assign flag_v = flags[FLAG_V];
  assign flag_z = flags[FLAG_Z];

  always_comb begin
    cond_met = 1'b0;
    case (cond_t'(cond))
      COND_NE:  cond_met = ~flag_z;
      COND_EQ:  cond_met = flag_z;
      COND_GT:  cond_met = ~flag_z & ~flag_n;
      COND_LT:  cond_met = flag_n;
      // Z | (~Z & ~N) reduces to Z | ~N
      COND_GE:  cond_met = flag_z | ~flag_n;
      COND_LE:  cond_met = flag_n | flag_z;
      COND_OVF: cond_met = flag_v;
      COND_AL:  cond_met = 1'b1;
      default:  cond_met = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: architectural program counter with branch resolution and
// stall/halt control for the single-cycle core.
// Ports:
//   clk, rst   clock (rising edge), asynchronous active-high reset
//   stall      hold PC and state this cycle (wins over halt)
//   halt       HLT decoded this cycle (wins over branch)
//   br_valid   current instruction is a branch
//   br_mode    0 = PC-relative, 1 = register-indirect
//   cond       branch condition code
//   flags      {N, V, Z}
//   imm        signed branch offset in half-words
//   br_target  register target for indirect branches
//   pc         registered current PC
//   pc_next    combinational next-PC candidate
//   taken      combinational branch-taken indication (0 while halted)
//   halted     registered, FSM is in HALTED
//   br_count   [optional, PC_BRANCH_COUNT_EN] saturating count of taken
//              branches that actually updated the PC
module pc_unit
  import pc_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                IMM_W    = 9,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    halt,
  input  logic                    br_valid,
  input  logic                    br_mode,
  input  logic [2:0]              cond,
  input  logic [2:0]              flags,
  input  logic signed [IMM_W-1:0] imm,
  input  logic [DATA_W-1:0]       br_target,
  output logic [DATA_W-1:0]       pc,
  output logic [DATA_W-1:0]       pc_next,
  output logic                    taken,
  output logic                    halted
`ifdef PC_BRANCH_COUNT_EN
  ,
  output logic [31:0]             br_count
`endif
);

  pc_state_t                state_p0;
  pc_state_t                state_d;
  logic [DATA_W-1:0]        pc_p0;
  logic [DATA_W-1:0]        pc_d;
  logic                     cond_met;
  logic [DATA_W-1:0]        seq_pc;
  logic [DATA_W-1:0]        rel_pc;
  logic [DATA_W-1:0]        reg_pc;
  logic signed [DATA_W-1:0] imm_ext;
  logic signed [DATA_W-1:0] rel_off;
  logic                     pc_upd;

  branch_cond_eval u_cond (
    .cond     (cond),
    .flags    (flags),
    .cond_met (cond_met)
  );

  assign imm_ext = DATA_W'(imm);
  assign rel_off = imm_ext <<< 1;
  assign seq_pc  = pc_p0 + DATA_W'(2);
  assign rel_pc  = seq_pc + $unsigned(rel_off);
  // Indirect targets are half-word aligned; bit 0 of the register is dropped.
  assign reg_pc  = br_target & {{(DATA_W-1){1'b1}}, 1'b0};

  assign taken   = br_valid & cond_met & (state_p0 == ST_RUN);
  assign pc_next = !taken ? seq_pc : (br_mode ? reg_pc : rel_pc);
  assign pc_upd  = (state_p0 == ST_RUN) & ~stall & ~halt;

  assign pc      = pc_p0;
  assign halted  = (state_p0 == ST_HALTED);

  always_comb begin
    state_d = state_p0;
    pc_d    = pc_p0;
    case (state_p0)
      ST_RUN: begin
        if (!stall) begin
          if (halt) state_d = ST_HALTED;
          else      pc_d    = pc_next;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Stage p0: architectural PC and control state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0 <= ST_RUN;
      pc_p0    <= RESET_PC;
    end else begin
      state_p0 <= state_d;
      pc_p0    <= pc_d;
    end
  end

`ifdef PC_BRANCH_COUNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  br_count <= '0;
    else if (taken && pc_upd) br_count <= sat_inc(br_count);
  end
`endif

endmodule
